// File: rtl/decode_ea_sequencer_pkg.sv
// Shared encodings for the EA decoder: segment, GPR and scale codes plus FSM states.
// Code 0 is NUL (or x1 for scale) so a cleared register reads as "nothing selected".
package decode_ea_sequencer_pkg;

  localparam int info_reg_seg_len = 3;
  localparam logic [info_reg_seg_len-1:0] info_reg_seg_nul = 3'd0;
  localparam logic [info_reg_seg_len-1:0] info_reg_seg_es  = 3'd1;
  localparam logic [info_reg_seg_len-1:0] info_reg_seg_cs  = 3'd2;
  localparam logic [info_reg_seg_len-1:0] info_reg_seg_ss  = 3'd3;
  localparam logic [info_reg_seg_len-1:0] info_reg_seg_ds  = 3'd4;
  localparam logic [info_reg_seg_len-1:0] info_reg_seg_fs  = 3'd5;
  localparam logic [info_reg_seg_len-1:0] info_reg_seg_gs  = 3'd6;

  localparam int info_reg_gpr_len = 4;
  localparam logic [info_reg_gpr_len-1:0] info_reg_gpr_nul = 4'd0;
  localparam logic [info_reg_gpr_len-1:0] info_reg_gpr_eax = 4'd1;
  localparam logic [info_reg_gpr_len-1:0] info_reg_gpr_ecx = 4'd2;
  localparam logic [info_reg_gpr_len-1:0] info_reg_gpr_edx = 4'd3;
  localparam logic [info_reg_gpr_len-1:0] info_reg_gpr_ebx = 4'd4;
  localparam logic [info_reg_gpr_len-1:0] info_reg_gpr_esp = 4'd5;
  localparam logic [info_reg_gpr_len-1:0] info_reg_gpr_ebp = 4'd6;
  localparam logic [info_reg_gpr_len-1:0] info_reg_gpr_esi = 4'd7;
  localparam logic [info_reg_gpr_len-1:0] info_reg_gpr_edi = 4'd8;

  localparam int info_scale_len = 2;
  localparam logic [info_scale_len-1:0] info_scale_x1 = 2'd0;
  localparam logic [info_scale_len-1:0] info_scale_x2 = 2'd1;
  localparam logic [info_scale_len-1:0] info_scale_x4 = 2'd2;
  localparam logic [info_scale_len-1:0] info_scale_x8 = 2'd3;

  localparam logic [1:0] S_MODRM = 2'd0;
  localparam logic [1:0] S_SIB   = 2'd1;
  localparam logic [1:0] S_DISP  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  // 3-bit x86 register field to GPR code
  function automatic logic [info_reg_gpr_len-1:0] gpr(input logic [2:0] enc);
    return {1'b0, enc} + 4'd1;
  endfunction

endpackage

// File: rtl/decode_ea_sequencer_ea_table_lookup.sv
// Combinational ModR/M + SIB decode table: base, index, scale, default segment,
// displacement length and whether a SIB byte follows.
module ea_table_lookup
  import decode_ea_sequencer_pkg::*;
(
  input  logic                        addr32,
  input  logic [1:0]                  mod,
  input  logic [2:0]                  rm,
  input  logic [7:0]                  sib,
  output logic [info_reg_gpr_len-1:0] base,
  output logic [info_reg_gpr_len-1:0] index,
  output logic [info_scale_len-1:0]   scale,
  output logic [info_reg_seg_len-1:0] dseg,
  output logic [2:0]                  disp_len,
  output logic                        sib_needed
);

  logic [2:0] bsel;

  always_comb begin
    base       = info_reg_gpr_nul;
    index      = info_reg_gpr_nul;
    scale      = info_scale_x1;
    dseg       = info_reg_seg_nul;
    disp_len   = 3'd0;
    sib_needed = 1'b0;
    bsel       = rm;
    if (mod != 2'b11) begin
      if (addr32) begin
        if (rm == 3'b100) begin
          sib_needed = 1'b1;
          scale      = sib[7:6];
          bsel       = sib[2:0];
          if (sib[5:3] != 3'b100) index = gpr(sib[5:3]);
        end
        // mod 00 with base encoding 101 means absolute disp32, no base
        if (mod == 2'b00 && bsel == 3'b101) disp_len = 3'd4;
        else begin
          base     = gpr(bsel);
          disp_len = (mod == 2'b01) ? 3'd1 : (mod == 2'b10) ? 3'd4 : 3'd0;
        end
      end else begin
        case (rm)
          3'd0: begin base = info_reg_gpr_ebx; index = info_reg_gpr_esi; end
          3'd1: begin base = info_reg_gpr_ebx; index = info_reg_gpr_edi; end
          3'd2: begin base = info_reg_gpr_ebp; index = info_reg_gpr_esi; end
          3'd3: begin base = info_reg_gpr_ebp; index = info_reg_gpr_edi; end
          3'd4: base = info_reg_gpr_esi;
          3'd5: base = info_reg_gpr_edi;
          3'd6: base = info_reg_gpr_ebp;
          default: base = info_reg_gpr_ebx;
        endcase
        if (mod == 2'b00 && rm == 3'b110) begin
          base     = info_reg_gpr_nul;
          disp_len = 3'd2;
        end else begin
          disp_len = (mod == 2'b01) ? 3'd1 : (mod == 2'b10) ? 3'd2 : 3'd0;
        end
      end
      dseg = (base == info_reg_gpr_esp || base == info_reg_gpr_ebp) ? info_reg_seg_ss
                                                                      : info_reg_seg_ds;
    end
  end

endmodule

// File: rtl/decode_ea_sequencer.sv
// Byte-serial effective-address decoder: ModR/M, optional SIB, 0/1/2/4 disp bytes
// in, one resolved addressing record out per operand.
module decode_ea_sequencer
  import decode_ea_sequencer_pkg::*;
#(
  parameter int ADDR16_EN = 1,
  parameter int DISP_W    = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        addr32,
  input  logic                        seg_ovr_valid,
  input  logic [info_reg_seg_len-1:0] seg_ovr,
  input  logic                        in_valid,
  input  logic [7:0]                  in_byte,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [1:0]                  out_mod,
  output logic [2:0]                  out_reg,
  output logic [2:0]                  out_rm,
  output logic                        out_is_reg,
  output logic                        out_addr32,
  output logic [info_reg_seg_len-1:0] out_segment,
  output logic [info_reg_gpr_len-1:0] out_base,
  output logic [info_reg_gpr_len-1:0] out_index,
  output logic [info_scale_len-1:0]   out_scale,
  output logic [DISP_W-1:0]           out_disp,
  output logic [2:0]                  out_length
);

  logic [1:0]                  state;
  logic [1:0]                  mod_r;
  logic [2:0]                  reg_r, rm_r;
  logic                        a32_r, ovr_v_r;
  logic [info_reg_seg_len-1:0] ovr_r, dseg_r;
  logic [7:0]                  sib_r;
  logic [info_reg_gpr_len-1:0] base_r, index_r;
  logic [info_scale_len-1:0]   scale_r;
  logic [2:0]                  dlen_r, len_r;
  logic [1:0]                  cnt;
  logic [31:0]                 raw, disp32;

  logic                        a32_in, accept;
  logic                        l_a32;
  logic [1:0]                  l_mod;
  logic [2:0]                  l_rm;
  logic [7:0]                  l_sib;
  logic [info_reg_gpr_len-1:0] lk_base, lk_index;
  logic [info_scale_len-1:0]   lk_scale;
  logic [info_reg_seg_len-1:0] lk_dseg;
  logic [2:0]                  lk_dlen;
  logic                        lk_sib;

  assign a32_in = addr32 | (ADDR16_EN == 0);
  assign accept = in_valid & in_ready;

  // Feed the table with the live byte in the state that is consuming it
  assign l_a32 = (state == S_MODRM) ? a32_in : a32_r;
  assign l_mod = (state == S_MODRM) ? in_byte[7:6] : mod_r;
  assign l_rm  = (state == S_MODRM) ? in_byte[2:0] : rm_r;
  assign l_sib = (state == S_SIB) ? in_byte : sib_r;

  ea_table_lookup u_lookup (
    .addr32     (l_a32),
    .mod        (l_mod),
    .rm         (l_rm),
    .sib        (l_sib),
    .base       (lk_base),
    .index      (lk_index),
    .scale      (lk_scale),
    .dseg       (lk_dseg),
    .disp_len   (lk_dlen),
    .sib_needed (lk_sib)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_MODRM;
      mod_r   <= '0;
      reg_r   <= '0;
      rm_r    <= '0;
      a32_r   <= 1'b0;
      ovr_v_r <= 1'b0;
      ovr_r   <= info_reg_seg_nul;
      dseg_r  <= info_reg_seg_nul;
      sib_r   <= '0;
      base_r  <= info_reg_gpr_nul;
      index_r <= info_reg_gpr_nul;
      scale_r <= info_scale_x1;
      dlen_r  <= '0;
      len_r   <= '0;
      cnt     <= '0;
      raw     <= '0;
    end else if (flush) begin
      state <= S_MODRM;
    end else begin
      case (state)
        S_MODRM: if (accept) begin
          mod_r   <= in_byte[7:6];
          reg_r   <= in_byte[5:3];
          rm_r    <= in_byte[2:0];
          a32_r   <= a32_in;
          ovr_v_r <= seg_ovr_valid;
          ovr_r   <= seg_ovr;
          base_r  <= lk_base;
          index_r <= lk_index;
          scale_r <= lk_scale;
          dseg_r  <= lk_dseg;
          dlen_r  <= lk_dlen;
          len_r   <= lk_sib ? 3'd1 : 3'd1 + lk_dlen;
          cnt     <= '0;
          raw     <= '0;
          if (in_byte[7:6] == 2'b11) state <= S_OUT;
          else if (lk_sib)           state <= S_SIB;
          else if (lk_dlen != 3'd0)  state <= S_DISP;
          else                       state <= S_OUT;
        end
        S_SIB: if (accept) begin
          sib_r   <= in_byte;
          base_r  <= lk_base;
          index_r <= lk_index;
          scale_r <= lk_scale;
          dseg_r  <= lk_dseg;
          dlen_r  <= lk_dlen;
          len_r   <= 3'd2 + lk_dlen;
          state   <= (lk_dlen != 3'd0) ? S_DISP : S_OUT;
        end
        S_DISP: if (accept) begin
          raw[{cnt, 3'b000} +: 8] <= in_byte;
          cnt <= cnt + 2'd1;
          if ({1'b0, cnt} == dlen_r - 3'd1) state <= S_OUT;
        end
        default: if (out_ready) state <= S_MODRM;
      endcase
    end
  end

  always_comb begin
    case (dlen_r)
      3'd1:    disp32 = {{24{raw[7]}}, raw[7:0]};
      3'd2:    disp32 = {{16{raw[15]}}, raw[15:0]};
      default: disp32 = raw;
    endcase
  end

  assign in_ready    = (state != S_OUT);
  assign out_valid   = (state == S_OUT);
  assign out_mod     = mod_r;
  assign out_reg     = reg_r;
  assign out_rm      = rm_r;
  assign out_is_reg  = (mod_r == 2'b11);
  assign out_addr32  = a32_r;
  // Register operands never touch memory, so they carry no segment at all
  assign out_segment = out_is_reg ? info_reg_seg_nul : (ovr_v_r ? ovr_r : dseg_r);
  assign out_base    = base_r;
  assign out_index   = index_r;
  assign out_scale   = scale_r;
  assign out_disp    = DISP_W'($signed(disp32));
  assign out_length  = len_r;

endmodule

// File: doc/decode_ea_sequencer.md
Name: decode_ea_sequencer

Overview:
- Byte-serial effective-address decoder for the 80386 decode stage.
- Consumes the ModR/M byte, an optional SIB byte and 0/1/2/4 displacement bytes from the prefetch-queue byte stream.
- Produces one fully resolved addressing record (segment, base, index, scale, sign-extended displacement, byte count) per operand.
- Supports 16-bit and 32-bit address size and segment override; sits between the prefetch queue and the operand-fetch/AGU stage.

Parameters:
- ADDR16_EN, 1: enable the 16-bit addressing table. When 0, addr32 is ignored and treated as 1.
- DISP_W, 32: width of out_disp. Must be ≥ 16; values wider than 32 are sign-extended.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous abort: discard partial record and any held output
- addr32  in  1  address size, 1 = 32-bit; sampled when the ModR/M byte is accepted
- seg_ovr_valid  in  1  segment-override prefix present; sampled with ModR/M
- seg_ovr  in  `info_reg_seg_len  override segment
- in_valid  in  1  in_byte valid
- in_byte  in  8  next instruction byte
- in_ready  out  1  byte accepted when in_valid & in_ready
- out_valid  out  1  record valid
- out_ready  in  1  consumer accepts the record
- out_mod  out  2  ModR/M mod field
- out_reg  out  3  ModR/M reg field
- out_rm  out  3  ModR/M r/m field
- out_is_reg  out  1  mod == 11 (register operand, no memory access)
- out_addr32  out  1  sampled address size
- out_segment  out  `info_reg_seg_len  effective segment
- out_base  out  `info_reg_gpr_len  base register, or NUL
- out_index  out  `info_reg_gpr_len  index register, or NUL
- out_scale  out  `info_scale_len  index scale
- out_disp  out  DISP_W  sign-extended displacement
- out_length  out  3  bytes consumed, 1..6

Behaviour:
- FSM states: S_MODRM, S_SIB, S_DISP, S_OUT. Reset and flush force S_MODRM. Flush has priority over all handshakes.
- Reset values: out_valid=0, in_ready=1, all record outputs 0 (segment/base/index = NUL, scale = x1).
- in_ready = 1 in S_MODRM, S_SIB and S_DISP; 0 in S_OUT. out_valid = 1 only in S_OUT.
- S_MODRM, on accept: latch mod/reg/rm, addr32 and override.
  - mod == 11 → S_OUT.
  - 32-bit with rm == 100 → S_SIB.
  - disp_len > 0 → S_DISP.
  - otherwise → S_OUT.
- S_SIB, on accept: scale 00/01/10/11 → x1/x2/x4/x8. index == 100 → NUL, else the GPR with that encoding.
- 32-bit, non-SIB:
  - rm 000–111 select EAX, ECX, EDX, EBX, (SIB), EBP, ESI, EDI as base.
  - mod 00 with rm 101: base NUL, disp32, DS.
- 32-bit, SIB base field:
  - base == 100: ESP.
  - base == 101 with mod 00: base NUL, disp32.
  - base == 101 with mod 01/10: base EBP.
- 16-bit (ADDR16_EN only):
  - rm 000 BX+SI, 001 BX+DI, 010 BP+SI, 011 BP+DI, 100 SI, 101 DI, 110 BP, 111 BX.
  - BX/BP/SI/DI are reported as EBX/EBP/ESI/EDI with out_addr32 = 0.
  - mod 00 with rm 110: no base, disp16.
- Displacement length:
  - mod 01: 1 byte.
  - mod 10: 4 bytes in 32-bit mode, 2 bytes in 16-bit mode.
  - mod 00: per the disp32/disp16 cases above, else 0.
- Displacement assembly: little-endian; byte k lands at bits [8k+7:8k]. A 2-bit counter tracks bytes; on the last byte → S_OUT. Displacement is sign-extended to DISP_W from 8/16/32 bits.
- Default segment: SS when the base is ESP or EBP, else DS. An accepted override replaces it. Register operands report segment NUL.
- out_length = 1 + SIB byte + displacement bytes.
- In-record gaps: in_valid may drop between bytes; state is held, no timeout.
- S_OUT: all outputs stable while out_ready = 0. When out_valid & out_ready → S_MODRM next cycle (no same-cycle bypass), and record outputs hold their last value.
- Reset or flush mid-record: the partially collected record is lost. The next accepted byte is treated as a ModR/M byte.

Decomposition:
- Shared package (definition.h successor): info_reg_seg_*, info_reg_gpr_*, info_scale_* encodings and lengths, plus the FSM state enum.
- One combinational sub-module, ea_table_lookup, maps (addr32, mod, rm, sib) to base, index, scale, default segment, disp_len and sib_needed. The FSM, counter and output registers stay in the top module.

Test Plan:
1. addr32=1, bytes 44 8D 10 → SS, base EBP, index ECX, x4, disp 0x00000010, length 3.
2. addr32=1, bytes 05 78 56 34 12 → DS, base NUL, index NUL, disp 0x12345678, length 5. Repeat 04 24 with seg_ovr=ES → ES, base ESP, index NUL, length 2.
3. addr32=0, bytes 46 FE → SS, base EBP, index NUL, disp 0xFFFFFFFE, length 2. Bytes 06 34 12 → DS, no base, disp 0x00001234, length 3.
4. Byte C3 → out_is_reg=1, out_rm=011, segment NUL, length 1, out_valid on the cycle after accept.
5. Case 2 with in_valid gaps between displacement bytes and out_ready held low 3 cycles → identical record; outputs stable; in_ready=0 while held.
6. Flush after 05 78 56 → out_valid stays 0; next byte C0 decodes as a register record of length 1. Reset in S_OUT → out_valid=0 the next cycle.
